// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one fixed-point multiplier among NREQ requesters.
// Each accepted operation is issued, computed and returned before the next grant.

module fp_mult #(
    parameter int n        = 8,
    parameter int f        = 7,
    parameter int ROUNDING = 0
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] p
);
    localparam int RSH = (f > 0) ? f - 1 : 0;
    localparam logic [2*n-1:0] RND = (ROUNDING != 0 && f > 0) ? ((2*n)'(1) << RSH) : '0;

    logic signed [2*n-1:0] ax, bx, full;

    assign ax   = (2*n)'($signed(a));
    assign bx   = (2*n)'($signed(b));
    // Default build truncates toward -inf; ROUNDING adds half an LSB first.
    assign full = ax * bx + $signed(RND);
    assign p    = n'(full >>> f);
endmodule

module fp_mult_arbiter #(
    parameter int n    = 8,
    parameter int f    = 7,
    parameter int NREQ = 2
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*n-1:0] req_a,
    input  logic [NREQ*n-1:0] req_b,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [n-1:0]      resp_result,
    output logic              busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t state, state_nxt;

    logic [NREQ-1:0][n-1:0] a_v, b_v;
    logic [IW-1:0]          ptr, gnt, g_q;
    logic                   found;
    logic [n-1:0]           a_q, b_q, prod;
    logic [NREQ-1:0]        rdy_raw;
    int                     scan;

    assign a_v = req_a;
    assign b_v = req_b;

    // Rotating priority: first valid requester at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        scan  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[scan]) begin
                found = 1'b1;
                gnt   = IW'(scan);
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy_raw   = '0;
        case (state)
            IDLE: if (found) begin
                rdy_raw[gnt] = 1'b1;
                state_nxt    = CALC;
            end
            CALC: state_nxt = RESP;
            RESP: if (resp_ready[g_q]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Held in reset the block presents no grant even though it sits in IDLE.
    assign req_ready = rdy_raw & {NREQ{nReset}};
    assign busy      = (state != IDLE);

    fp_mult #(.n(n), .f(f)) u_mult (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            ptr         <= '0;
            g_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            resp_valid  <= '0;
            resp_result <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    a_q <= a_v[gnt];
                    b_q <= b_v[gnt];
                    g_q <= gnt;
                    ptr <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
                end
                CALC: begin
                    resp_result <= prod;
                    resp_valid  <= NREQ'(1) << g_q;
                end
                RESP: if (resp_ready[g_q]) resp_valid <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Randomized and directed bench for fp_mult_arbiter against a transaction-level model.
module tb_fp_mult_arbiter;
    localparam int N = 8;
    localparam int F = 7;
    localparam int R = 2;

    logic           clock = 1'b0;
    logic           nReset;
    logic [R-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [R*N-1:0] req_a, req_b;
    logic [N-1:0]   resp_result;
    logic           busy;

    fp_mult_arbiter #(.n(N), .f(F), .NREQ(R)) dut (
        .clock       (clock),
        .nReset      (nReset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // a*b/2^f, floor (the build truncates), wrapped to n bits.
    function automatic logic [N-1:0] gold(input logic [N-1:0] a, input logic [N-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return N'(p >>> F);
    endfunction

    function automatic int pick(input logic [R-1:0] v, input int ptr);
        for (int k = 0; k < R; k++)
            if (v[(ptr + k) % R]) return (ptr + k) % R;
        return -1;
    endfunction

    // Model: one outstanding transaction; age 0 = computing, age 1 = offered.
    int           m_ptr, m_g, m_age, m_pick;
    bit           m_out;
    logic [N-1:0] m_res, m_last;

    always @(posedge clock) cyc++;

    always @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            m_ptr = 0; m_out = 0; m_age = 0; m_g = 0; m_last = '0; m_res = '0;
        end else if (!m_out) begin
            m_pick = pick(req_valid, m_ptr);
            if (m_pick >= 0) begin
                m_out = 1; m_age = 0; m_g = m_pick;
                m_res = gold(req_a[m_pick*N +: N], req_b[m_pick*N +: N]);
                m_ptr = (m_pick + 1) % R;
            end
        end else if (m_age == 0) begin
            m_age = 1;
            m_last = m_res;
        end else if (resp_ready[m_g]) begin
            m_out = 0;
        end
    end

    logic [R-1:0] exp_rr, exp_rv;
    int           cp;
    always @(negedge clock) begin
        cp = pick(req_valid, m_ptr);
        exp_rr = (nReset && !m_out && cp >= 0) ? R'(1) << cp : '0;
        exp_rv = (m_out && m_age == 1) ? R'(1) << m_g : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_result", 32'(resp_result), 32'(m_last));
        chk("busy", 32'(busy), 32'(m_out));
    end

    // Monitor of handshakes for the directed order/spacing checks and the driver.
    logic [R-1:0] acc_seen;
    bit           rec = 0;
    int           gq_idx[$], gq_cyc[$], rq_idx[$];
    logic [N-1:0] rq_res[$];
    always @(negedge clock) begin
        acc_seen = req_valid & req_ready;
        if (rec) begin
            for (int i = 0; i < R; i++) begin
                if (acc_seen[i]) begin gq_idx.push_back(i); gq_cyc.push_back(cyc); end
                if (resp_valid[i] && resp_ready[i]) begin
                    rq_idx.push_back(i); rq_res.push_back(resp_result);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic wait_acc(input int i, input string name);
        bit ok = 0;
        for (int t = 0; t < 30 && !ok; t++) begin
            @(negedge clock); #1;
            if (req_ready[i] && req_valid[i]) ok = 1;
        end
        if (!ok) chk(name, 0, 1);
    endtask

    function automatic logic [N-1:0] rnd_op();
        case ($urandom_range(0, 4))
            0: return 8'h80;
            1: return 8'h7F;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        nReset = 0; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clock);
        #1;
        req_a = {8'h10, 8'h40};
        req_b = {8'hC0, 8'h40};
        req_valid = 2'b11;
        resp_ready = 2'b11;
        @(negedge clock); #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_result", 32'(resp_result), 0);
        chk("rst_busy", 32'(busy), 0);

        // Contention straight out of reset.
        tick();
        nReset = 1; rec = 1;
        @(negedge clock); #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        for (int t = 0; t < 40 && gq_idx.size() < 4; t++) begin @(negedge clock); #1; end
        chk("cont_ngrants", gq_idx.size(), 4);
        tick();
        req_valid = '0;
        repeat (4) tick();
        rec = 0;
        if (gq_idx.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("cont_order", gq_idx[k], k % 2);
            for (int k = 1; k < 4; k++) chk("cont_spacing", gq_cyc[k] - gq_cyc[k-1], 3);
        end
        chk("cont_nresp", rq_idx.size(), 4);
        if (rq_idx.size() >= 4)
            for (int k = 0; k < 4; k++) begin
                chk("cont_resp_idx", rq_idx[k], k % 2);
                chk("cont_resp_res", 32'(rq_res[k]), (k % 2) ? 32'hF8 : 32'h20);
            end

        // Backpressure on requester 0 while requester 1 waits.
        resp_ready = 2'b00;
        req_valid = 2'b01;
        wait_acc(0, "bp_acc0_timeout");
        tick();
        req_valid = 2'b10;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clock); #1;
            chk("bp_resp_valid", 32'(resp_valid), 32'h1);
            chk("bp_result", 32'(resp_result), 32'h20);
            chk("bp_req_ready", 32'(req_ready), 0);
            tick();
        end
        resp_ready = 2'b01;
        tick();
        @(negedge clock); #1;
        chk("bp_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        resp_ready = 2'b11;
        repeat (4) tick();

        // Reset pulse while an operation is in CALC.
        req_valid = 2'b01;
        wait_acc(0, "mr_acc_timeout");
        tick();
        req_valid = '0;
        nReset = 0;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_resp_valid", 32'(resp_valid), 0);
        #6;
        nReset = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); #1;
            chk("mr_no_resp", 32'(resp_valid), 0);
        end
        tick();
        req_valid = 2'b10;
        wait_acc(1, "mr_acc1_timeout");
        @(posedge clock);
        @(posedge clock);
        @(negedge clock); #1;
        chk("mr_after_valid", 32'(resp_valid), 32'h2);
        chk("mr_after_res", 32'(resp_result), 32'hF8);
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Randomized traffic; requesters keep valid/operands until accepted.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < R; i++) begin
                if (acc_seen[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_a[i*N +: N] = rnd_op();
                    req_b[i*N +: N] = rnd_op();
                end
            end
            resp_ready = R'($urandom_range(0, 3));
            tick();
        end
        req_valid = '0;
        resp_ready = 2'b11;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
